data_mem_ctrl: RTL and testbench

- Memory-side responder for the processor's data-memory interface; consumes the MemWrite/memSelect access requests the controller issues.
- Owns a word-wide single-port synchronous RAM; performs word/halfword/byte loads (zero- or sign-extended) and stores; sub-word stores use read-modify-write.
- Raises stall to the core until each access completes; flags misaligned accesses without touching memory.

---
 rtl/data_mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Memory-side responder for the core's data-memory interface. Owns a
// 2**ADDR_W x 32 single-port synchronous RAM and services word, halfword and
// byte loads (zero- or sign-extended) and stores. Sub-word stores are done as
// read-modify-write. Misaligned or illegal requests are aborted without
// touching the RAM and flagged with misalign alongside done.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, returns the block to IDLE
//   req       access request, held by the core until done
//   MemWrite  1 = store, 0 = load (captured on acceptance)
//   memSelect 000 word, 001 byte u, 010 half u, 011 byte s, 100 half s
//   addr      byte address; [ADDR_W+1:2] word index, [1:0] lane
//   wdata     store data (byte in [7:0], half in [15:0])
//   rdata     load result, valid while done=1 on a load, held afterwards
//   done      one-cycle completion pulse
//   misalign  one-cycle pulse with done for an aborted access
//   stall     req & ~done
//
// state  | meaning
// IDLE   | waiting for req; captures the request on acceptance
// ERR    | misaligned/illegal access, done+misalign, no RAM access
// WR     | full-word RAM write, done
// RD     | RAM read issued for a load
// RESP   | extended load data presented on rdata, done
// RMW_RD | RAM read issued for a sub-word store
// RMW_WR | merged word written back, done

module data_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [2:0]  memSelect,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        stall
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ERR    = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RD     = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;
  localparam logic [2:0] RMW_RD = 3'd5;
  localparam logic [2:0] RMW_WR = 3'd6;

  logic [2:0]        state, state_nxt;
  logic              we_q;
  logic [2:0]        sel_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram_q;
  logic [31:0]       mem [2**ADDR_W];

  logic              bad_req;
  logic [31:0]       ext_data;
  logic [31:0]       merged;
  logic [31:0]       lane_shift;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_idx;

  // Address bits above the RAM index alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    bad_req = 1'b0;
    case (memSelect)
      3'b000:  bad_req = (addr[1:0] != 2'b00);
      3'b001:  bad_req = 1'b0;
      3'b010:  bad_req = addr[0];
      3'b011:  bad_req = MemWrite;
      3'b100:  bad_req = MemWrite | addr[0];
      default: bad_req = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_req)                   state_nxt = ERR;
          else if (!MemWrite)            state_nxt = RD;
          else if (memSelect == 3'b000)  state_nxt = WR;
          else                           state_nxt = RMW_RD;
        end
      end
      RD:      state_nxt = RESP;
      RMW_RD:  state_nxt = RMW_WR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        we_q    <= MemWrite;
        sel_q   <= memSelect;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
      end
      if (state == RESP)
        rdata_q <= ext_data;
    end
  end

  assign lane_shift = ram_q >> {addr_q[1:0], 3'b000};
  assign byte_v     = lane_shift[7:0];
  assign half_v     = addr_q[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    ext_data = ram_q;
    case (sel_q)
      3'b001:  ext_data = {24'd0, byte_v};
      3'b010:  ext_data = {16'd0, half_v};
      3'b011:  ext_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  ext_data = {{16{half_v[15]}}, half_v};
      default: ext_data = ram_q;
    endcase
  end

  always_comb begin
    merged = ram_q;
    if (sel_q == 3'b001)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (sel_q == 3'b010) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Gating with reset keeps a write from landing on the edge where reset is
  // already asserted.
  assign ram_idx = addr_q[ADDR_W+1:2];
  assign ram_we  = ((state == WR) || (state == RMW_WR)) && !reset;
  assign ram_re  = (state == RD) || (state == RMW_RD);

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_idx] <= (state == WR) ? wdata_q : merged;
    if (ram_re)
      ram_q <= mem[ram_idx];
  end

  // During RESP the freshly extracted value is shown directly so rdata is
  // valid in the same cycle as done; afterwards the registered copy holds it.
  assign rdata    = (state == RESP) ? ext_data : rdata_q;
  assign done     = (state == ERR) || (state == WR) || (state == RESP) || (state == RMW_WR);
  assign misalign = (state == ERR);
  assign stall    = req & ~done;

  // we_q is kept for debug visibility of the captured direction.
  logic unused_we_q;
  assign unused_we_q = we_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        MemWrite;
  logic [2:0]  memSelect;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        misalign;
  logic        stall;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req(req), .MemWrite(MemWrite),
    .memSelect(memSelect), .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .misalign(misalign), .stall(stall)
  );

  always #5 clk = ~clk;

  // Issues one request starting just after a clock edge (block in IDLE) and
  // waits for done; returns cycles from accept edge to done, rdata, misalign.
  task automatic access(input logic we, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic mis);
    req = 1'b1; MemWrite = we; memSelect = sel; addr = a; wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 10);
    rd = rdata; mis = misalign;
    if (!done) begin
      errors++;
      $display("FAIL timeout: no done for addr %h sel %b (waited %0d cycles)", a, sel, lat);
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_load(input string name, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] exp);
    int lat; logic [31:0] rd; logic mis;
    access(1'b0, sel, a, 32'h0, lat, rd, mis);
    checks++;
    if (rd !== exp || lat !== 2 || mis !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdata %h lat %0d mis %b, expected rdata %h lat 2 mis 0",
               name, rd, lat, mis, exp);
    end
  endtask

  task automatic chk_store(input string name, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] d, input int exp_lat);
    int lat; logic [31:0] rd; logic mis;
    access(1'b1, sel, a, d, lat, rd, mis);
    checks++;
    if (lat !== exp_lat || mis !== 1'b0) begin
      errors++;
      $display("FAIL %s: lat %0d mis %b, expected lat %0d mis 0", name, lat, mis, exp_lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; MemWrite = 1'b0; memSelect = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0 || done !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdata %h done %b mis %b stall %b, expected 0 0 0 0",
               rdata, done, misalign, stall);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    chk_store("word_store_10", 3'b000, 32'h10, 32'hDEADBEEF, 1);
    chk_load("word_load_10", 3'b000, 32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_byte;
    chk_store("byte_store_11", 3'b001, 32'h11, 32'h000000AA, 2);
    chk_load("word_after_byte", 3'b000, 32'h10, 32'hDEADAAEF);
    chk_load("byte_signed_11", 3'b011, 32'h11, 32'hFFFFFFAA);
    chk_load("byte_unsigned_11", 3'b001, 32'h11, 32'h000000AA);
    chk_load("byte_unsigned_10", 3'b001, 32'h10, 32'h000000EF);
  endtask

  task automatic test_half;
    chk_store("half_store_12", 3'b010, 32'h12, 32'h00008001, 2);
    chk_load("half_signed_12", 3'b100, 32'h12, 32'hFFFF8001);
    chk_load("half_unsigned_12", 3'b010, 32'h12, 32'h00008001);
    chk_load("word_after_half", 3'b000, 32'h10, 32'h8001AAEF);
    chk_load("half_signed_10", 3'b100, 32'h10, 32'hFFFFAAEF);
  endtask

  task automatic test_misalign;
    int lat; logic [31:0] rd; logic mis;
    // rdata must keep the last load result (0xFFFFAAEF) through aborted accesses.
    access(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, mis);
    checks++;
    if (lat !== 1 || mis !== 1'b1 || rd !== 32'hFFFFAAEF) begin
      errors++;
      $display("FAIL misalign_word_load: lat %0d mis %b rdata %h, expected 1 1 ffffaaef", lat, mis, rd);
    end
    access(1'b1, 3'b010, 32'h11, 32'h0000FFFF, lat, rd, mis);
    checks++;
    if (lat !== 1 || mis !== 1'b1) begin
      errors++;
      $display("FAIL misalign_half_store: lat %0d mis %b, expected 1 1", lat, mis);
    end
    access(1'b1, 3'b011, 32'h10, 32'h00000055, lat, rd, mis);
    checks++;
    if (lat !== 1 || mis !== 1'b1) begin
      errors++;
      $display("FAIL illegal_signed_store: lat %0d mis %b, expected 1 1", lat, mis);
    end
    chk_load("word_after_misalign", 3'b000, 32'h10, 32'h8001AAEF);
  endtask

  task automatic test_reset_mid_rmw;
    req = 1'b1; MemWrite = 1'b1; memSelect = 3'b001; addr = 32'h10; wdata = 32'h00000077;
    @(posedge clk); #1;   // accepted, now in RMW_RD
    reset = 1'b1; req = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0 || done !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rmw: rdata %h done %b mis %b stall %b, expected 0 0 0 0",
               rdata, done, misalign, stall);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_load("word_after_reset", 3'b000, 32'h10, 32'h8001AAEF);
  endtask

  task automatic test_back_to_back;
    req = 1'b1; MemWrite = 1'b1; memSelect = 3'b000; addr = 32'h20; wdata = 32'h11112222;
    #1;
    checks++;
    if (stall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pre: stall %b done %b, expected 1 0", stall, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: done %b stall %b, expected 1 0", done, stall);
    end
    addr = 32'h24; wdata = 32'h33334444;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap: done %b stall %b, expected 0 1", done, stall);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: done %b stall %b, expected 1 0", done, stall);
    end
    req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: done %b, expected 0", done);
    end
    chk_load("b2b_word_20", 3'b000, 32'h20, 32'h11112222);
    chk_load("b2b_word_24", 3'b000, 32'h24, 32'h33334444);
  endtask

  task automatic test_req_drop_alias;
    int lat;
    // Load of 0x1010 aliases to word 0x10; req dropped right after accept.
    req = 1'b1; MemWrite = 1'b0; memSelect = 3'b000; addr = 32'h1010;
    @(posedge clk); #1;
    req = 1'b0; addr = 32'h20;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 2 || rdata !== 32'h8001AAEF) begin
      errors++;
      $display("FAIL req_drop_alias: done %b lat %0d rdata %h, expected 1 2 8001aaef",
               done, lat, rdata);
    end
    @(posedge clk); #1;
    chk_store("alias_byte_store", 3'b001, 32'h1013, 32'h00000012, 2);
    chk_load("alias_word_10", 3'b000, 32'h10, 32'h1201AAEF);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reset_mid_rmw();
    test_back_to_back();
    test_req_drop_alias();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
